// File: rtl/timer_param_pkg.sv
// Shared types and default sizes for the parametrised timer core and its channels.
package timer_param_pkg;

  localparam int DEF_NUM_CH = 8;
  localparam int DEF_CNT_W  = 32;
  localparam int DEF_PRE_W  = 3;

  typedef enum logic [1:0] {
    OC_NONE   = 2'b00,
    OC_TOGGLE = 2'b01,
    OC_CLEAR  = 2'b10,
    OC_SET    = 2'b11
  } oc_action_t;

  typedef enum logic [1:0] {
    IC_OFF  = 2'b00,
    IC_RISE = 2'b01,
    IC_FALL = 2'b10,
    IC_BOTH = 2'b11
  } ic_edge_t;

endpackage

// File: rtl/timer_channel.sv
// One capture/compare channel: pin synchroniser, edge detect, tc register, compare, flag, output pin.
// TIMER_FAST_FLAG_CLR_EN adds tfca so a tc write can also clear the flag.
module timer_channel
  import timer_param_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ten,
  input  logic             tick,
  input  logic [CNT_W-1:0] tcnt,
  input  logic             ios,
  input  logic             om,
  input  logic             ol,
  input  logic             edge_a,
  input  logic             edge_b,
  input  logic [CNT_W-1:0] wdata,
  input  logic             tc_wen,
  input  logic             tf_clr,
`ifdef TIMER_FAST_FLAG_CLR_EN
  input  logic             tfca,
`endif
  input  logic             ch_in,
  output logic [CNT_W-1:0] tc,
  output logic             tf,
  output logic             ch_out
);

  logic       sync_1, sync_2, sync_3;
  logic       rise, fall, edge_hit, capture, match, flag_clr;
  ic_edge_t   edge_sel;
  oc_action_t act;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      sync_3 <= 1'b0;
    end else begin
      sync_1 <= ch_in;
      sync_2 <= sync_1;
      sync_3 <= sync_2;
    end
  end

  always_comb begin
    edge_sel = ic_edge_t'({edge_b, edge_a});
    act      = oc_action_t'({om, ol});
    rise     = sync_2 & ~sync_3;
    fall     = ~sync_2 & sync_3;
    edge_hit = 1'b0;
    case (edge_sel)
      IC_RISE: edge_hit = rise;
      IC_FALL: edge_hit = fall;
      IC_BOTH: edge_hit = rise | fall;
      default: edge_hit = 1'b0;
    endcase
    // Capture runs on every clock, not just on prescaler ticks
    capture = ~ios & ten & edge_hit;
    match   = ios & tick & (tcnt == tc);
`ifdef TIMER_FAST_FLAG_CLR_EN
    flag_clr = tf_clr | (tfca & tc_wen);
`else
    flag_clr = tf_clr;
`endif
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      tc     <= '0;
      tf     <= 1'b0;
      ch_out <= 1'b0;
    end else begin
      if (capture)     tc <= tcnt;
      else if (tc_wen) tc <= wdata;

      if (capture || match) tf <= 1'b1;
      else if (flag_clr)    tf <= 1'b0;

      if (match) begin
        case (act)
          OC_TOGGLE: ch_out <= ~ch_out;
          OC_CLEAR:  ch_out <= 1'b0;
          OC_SET:    ch_out <= 1'b1;
          default:   ch_out <= ch_out;
        endcase
      end
    end
  end

endmodule

// File: rtl/timer_core_param.sv
// Timer core: prescaler, free-running counter with overflow, NUM_CH capture/compare channels, irq.
// TIMER_FAST_FLAG_CLR_EN adds tfca: tc writes clear channel flags, counter loads clear tovf.
module timer_core_param
  import timer_param_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int PRE_W  = DEF_PRE_W
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic                    ten,
  input  logic [PRE_W-1:0]        pre,
  input  logic                    tcre,
  input  logic [NUM_CH-1:0]       ios,
  input  logic [NUM_CH-1:0]       om,
  input  logic [NUM_CH-1:0]       ol,
  input  logic [NUM_CH-1:0]       edge_a,
  input  logic [NUM_CH-1:0]       edge_b,
  input  logic [NUM_CH-1:0]       tie,
  input  logic                    toi,
  input  logic [CNT_W-1:0]        wdata,
  input  logic [NUM_CH-1:0]       tc_wen,
  input  logic                    tcnt_wen,
  input  logic [NUM_CH-1:0]       tf_clr,
  input  logic                    tovf_clr,
`ifdef TIMER_FAST_FLAG_CLR_EN
  input  logic                    tfca,
`endif
  input  logic [NUM_CH-1:0]       ch_in,
  output logic [NUM_CH-1:0]       ch_out,
  output logic [CNT_W-1:0]        tcnt,
  output logic [NUM_CH*CNT_W-1:0] tc,
  output logic [NUM_CH-1:0]       tf,
  output logic                    tovf,
  output logic                    irq
);

  localparam int PCNT_W = (1 << PRE_W) - 1;

  logic [PCNT_W-1:0] pcnt, pre_mask;
  logic [CNT_W-1:0]  tc_last;
  logic              tick, mod_reset, ovf_set, ovf_clr;

  always_comb begin
    // Low pre bits of pcnt all-ones; pre=0 gives an empty mask and a tick every cycle
    pre_mask  = ~({PCNT_W{1'b1}} << pre);
    tick      = ten & ((pcnt & pre_mask) == pre_mask);
    tc_last   = tc[(NUM_CH-1)*CNT_W +: CNT_W];
    mod_reset = tcre & ios[NUM_CH-1] & (tcnt == tc_last);
    ovf_set   = tick & ~tcnt_wen & ~mod_reset & (tcnt == '1);
`ifdef TIMER_FAST_FLAG_CLR_EN
    ovf_clr   = tovf_clr | (tfca & tcnt_wen);
`else
    ovf_clr   = tovf_clr;
`endif
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pcnt <= '0;
      tcnt <= '0;
      tovf <= 1'b0;
      irq  <= 1'b0;
    end else begin
      if (tcnt_wen) pcnt <= '0;
      else if (ten) pcnt <= pcnt + PCNT_W'(1);

      if (tcnt_wen) tcnt <= wdata;
      else if (tick) begin
        if (mod_reset || (tcnt == '1)) tcnt <= '0;
        else                           tcnt <= tcnt + CNT_W'(1);
      end

      if (ovf_set)      tovf <= 1'b1;
      else if (ovf_clr) tovf <= 1'b0;

      irq <= (|(tf & tie)) | (tovf & toi);
    end
  end

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    timer_channel #(.CNT_W(CNT_W)) u_ch (
      .CLK    (CLK),
      .nRST   (nRST),
      .ten    (ten),
      .tick   (tick),
      .tcnt   (tcnt),
      .ios    (ios[n]),
      .om     (om[n]),
      .ol     (ol[n]),
      .edge_a (edge_a[n]),
      .edge_b (edge_b[n]),
      .wdata  (wdata),
      .tc_wen (tc_wen[n]),
      .tf_clr (tf_clr[n]),
`ifdef TIMER_FAST_FLAG_CLR_EN
      .tfca   (tfca),
`endif
      .ch_in  (ch_in[n]),
      .tc     (tc[n*CNT_W +: CNT_W]),
      .tf     (tf[n]),
      .ch_out (ch_out[n])
    );
  end

endmodule

// File: tb/tb_timer_core_param.sv
// Directed and random bench for timer_core_param (8 channels, 8-bit counter) against a behavioural model.
module tb_timer_core_param;

  localparam int NCH = 8;
  localparam int CW  = 8;
  localparam int PW  = 3;

  logic              CLK, nRST;
  logic              ten, tcre, toi, tcnt_wen, tovf_clr;
  logic [PW-1:0]     pre;
  logic [NCH-1:0]    ios, om, ol, edge_a, edge_b, tie, tc_wen, tf_clr, ch_in;
  logic [CW-1:0]     wdata;
`ifdef TIMER_FAST_FLAG_CLR_EN
  logic              tfca;
`endif
  logic [NCH-1:0]    ch_out, tf;
  logic [CW-1:0]     tcnt;
  logic [NCH*CW-1:0] tc;
  logic              tovf, irq;

  timer_core_param #(.NUM_CH(NCH), .CNT_W(CW), .PRE_W(PW)) dut (
    .CLK(CLK), .nRST(nRST), .ten(ten), .pre(pre), .tcre(tcre), .ios(ios),
    .om(om), .ol(ol), .edge_a(edge_a), .edge_b(edge_b), .tie(tie), .toi(toi),
    .wdata(wdata), .tc_wen(tc_wen), .tcnt_wen(tcnt_wen), .tf_clr(tf_clr),
    .tovf_clr(tovf_clr),
`ifdef TIMER_FAST_FLAG_CLR_EN
    .tfca(tfca),
`endif
    .ch_in(ch_in), .ch_out(ch_out), .tcnt(tcnt), .tc(tc), .tf(tf),
    .tovf(tovf), .irq(irq)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: counter and prescale phase as integers, pin history as sampled per edge
  int           m_tcnt, m_pcnt;
  int           m_tc[NCH];
  bit [NCH-1:0] m_tf, m_out;
  bit           m_tovf, m_irq;
  bit [NCH-1:0] hist[3];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_tcnt = 0; m_pcnt = 0; m_tf = '0; m_out = '0; m_tovf = 0; m_irq = 0;
    for (int i = 0; i < NCH; i++) m_tc[i] = 0;
    for (int i = 0; i < 3; i++) hist[i] = '0;
  endtask

  task automatic check_all(input string tag);
    logic [NCH*CW-1:0] exp_tc;
    for (int i = 0; i < NCH; i++) exp_tc[i*CW +: CW] = CW'(m_tc[i]);
    check({tag, "_tcnt"}, 64'(tcnt), 64'(m_tcnt));
    check({tag, "_tc"}, 64'(tc), 64'(exp_tc));
    check({tag, "_tf"}, 64'(tf), 64'(m_tf));
    check({tag, "_out"}, 64'(ch_out), 64'(m_out));
    check({tag, "_tovf"}, 64'(tovf), 64'(m_tovf));
    check({tag, "_irq"}, 64'(irq), 64'(m_irq));
  endtask

  // Predict the next state from the current inputs, clock once, then compare
  task automatic step(input string tag);
    int           n_tcnt, n_pcnt, div;
    int           n_tc[NCH];
    bit [NCH-1:0] n_tf, n_out, pin_now;
    bit           n_tovf, n_irq, tick, ovf_set, set, fast_tf, fast_ovf, s_new, s_old, edge_ok;
    div     = 1 << pre;
    tick    = ten && ((m_pcnt % div) == div - 1);
    n_tcnt  = m_tcnt; n_pcnt = m_pcnt; n_tc = m_tc;
    n_tf    = m_tf; n_out = m_out; n_tovf = m_tovf;
    ovf_set = 0;
    pin_now = ch_in;
    fast_ovf = 0;
`ifdef TIMER_FAST_FLAG_CLR_EN
    fast_ovf = tfca && tcnt_wen;
`endif
    if (ten) n_pcnt = (m_pcnt + 1) % 128;
    if (tick) begin
      if (tcre && ios[NCH-1] && m_tcnt == m_tc[NCH-1]) n_tcnt = 0;
      else if (m_tcnt == 255) begin n_tcnt = 0; ovf_set = 1; end
      else n_tcnt = m_tcnt + 1;
    end
    if (tcnt_wen) begin n_tcnt = int'(wdata); n_pcnt = 0; ovf_set = 0; end
    for (int n = 0; n < NCH; n++) begin
      set = 0;
      fast_tf = 0;
`ifdef TIMER_FAST_FLAG_CLR_EN
      fast_tf = tfca && tc_wen[n];
`endif
      if (tc_wen[n]) n_tc[n] = int'(wdata);
      if (ios[n]) begin
        if (tick && m_tcnt == m_tc[n]) begin
          set = 1;
          case ({om[n], ol[n]})
            2'b01:   n_out[n] = ~m_out[n];
            2'b10:   n_out[n] = 1'b0;
            2'b11:   n_out[n] = 1'b1;
            default: n_out[n] = m_out[n];
          endcase
        end
      end else begin
        s_new   = hist[1][n];
        s_old   = hist[2][n];
        edge_ok = (edge_a[n] && s_new && !s_old) || (edge_b[n] && !s_new && s_old);
        if (ten && edge_ok) begin set = 1; n_tc[n] = m_tcnt; end
      end
      if (set) n_tf[n] = 1'b1;
      else if (tf_clr[n] || fast_tf) n_tf[n] = 1'b0;
    end
    if (ovf_set) n_tovf = 1;
    else if (tovf_clr || fast_ovf) n_tovf = 0;
    n_irq = (|(m_tf & tie)) || (m_tovf && toi);
    @(posedge CLK);
    #1;
    m_tcnt = n_tcnt; m_pcnt = n_pcnt; m_tc = n_tc; m_tf = n_tf; m_out = n_out;
    m_tovf = n_tovf; m_irq = n_irq;
    hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = pin_now;
    check_all(tag);
  endtask

  initial begin
    int saved;
    nRST = 1'b1;
    ten = 0; pre = '0; tcre = 0; toi = 0; tcnt_wen = 0; tovf_clr = 0;
    ios = '0; om = '0; ol = '0; edge_a = '0; edge_b = '0; tie = '0;
    tc_wen = '0; tf_clr = '0; ch_in = '0; wdata = '0;
`ifdef TIMER_FAST_FLAG_CLR_EN
    tfca = 0;
`endif
    model_reset();
    #1 nRST = 1'b0;
    #10;
    check_all("reset");
    nRST = 1'b1;

    // Prescale by 4
    pre = 3'd2; ten = 1;
    for (int i = 0; i < 16; i++) step("pre4");
    check("pre4_tcnt16", 64'(tcnt), 64'd4);
    for (int i = 0; i < 3; i++) step("pre4b");
    ten = 0;
    saved = m_tcnt;
    for (int i = 0; i < 10; i++) step("frozen");
    check("frozen_tcnt", 64'(tcnt), 64'(saved));
    ten = 1;
    for (int i = 0; i < 7; i++) step("resume");

    // Asynchronous reset in the middle of a clock period
    #2 nRST = 1'b0;
    #1;
    model_reset();
    check_all("rst_async");
    nRST = 1'b1;

    // Overflow
    pre = 3'd0; toi = 1;
    tcnt_wen = 1; wdata = 8'hFE; step("ovf_load"); tcnt_wen = 0;
    check("ovf_fe", 64'(tcnt), 64'hFE);
    step("ovf_ff");
    check("ovf_tcnt_ff", 64'(tcnt), 64'hFF);
    check("ovf_not_yet", 64'(tovf), 64'd0);
    step("ovf_wrap");
    check("ovf_tcnt_00", 64'(tcnt), 64'h00);
    check("ovf_set", 64'(tovf), 64'd1);
    step("ovf_irq");
    check("ovf_irq1", 64'(irq), 64'd1);
    tovf_clr = 1; step("ovf_clr"); tovf_clr = 0;
    check("ovf_cleared", 64'(tovf), 64'd0);

    // Compare with toggle on channel 0
    ios[0] = 1; om[0] = 0; ol[0] = 1;
    tc_wen = 8'h01; wdata = 8'h10; step("cmp_wtc"); tc_wen = '0;
    tcnt_wen = 1; wdata = 8'h0C; step("cmp_load"); tcnt_wen = 0;
    for (int i = 0; i < 4; i++) step("cmp_run");
    check("cmp_before", 64'(tf[0]), 64'd0);
    step("cmp_hit");
    check("cmp_tf", 64'(tf[0]), 64'd1);
    check("cmp_out1", 64'(ch_out[0]), 64'd1);
    tf_clr = 8'h01; step("cmp_clr"); tf_clr = '0;
    for (int i = 0; i < 254; i++) step("cmp_wrap");
    check("cmp_out_hold", 64'(ch_out[0]), 64'd1);
    step("cmp_hit2");
    check("cmp_out0", 64'(ch_out[0]), 64'd0);
    check("cmp_tf2", 64'(tf[0]), 64'd1);

    // Counter modulus from channel 7
    tovf_clr = 1; step("mod_clr"); tovf_clr = 0;
    ios[7] = 1;
    tc_wen = 8'h80; wdata = 8'd9; step("mod_wtc"); tc_wen = '0;
    tcre = 1;
    tcnt_wen = 1; wdata = 8'd0; step("mod_load"); tcnt_wen = 0;
    for (int i = 0; i < 9; i++) step("mod_run");
    check("mod_top", 64'(tcnt), 64'd9);
    step("mod_back");
    check("mod_zero", 64'(tcnt), 64'd0);
    for (int i = 0; i < 30; i++) begin
      step("mod_loop");
      check("mod_bound", 64'(tcnt <= 8'd9), 64'd1);
    end
    check("mod_no_ovf", 64'(tovf), 64'd0);
    tcre = 0;

    // Rising-edge capture on channel 3
    edge_a[3] = 1; edge_b[3] = 0;
    tcnt_wen = 1; wdata = 8'h40; step("cap_load"); tcnt_wen = 0;
    ch_in[3] = 1;
    step("cap_s1");
    step("cap_s2");
    check("cap_early", 64'(tf[3]), 64'd0);
    step("cap_hit");
    check("cap_tc", 64'(tc[3*CW +: CW]), 64'h42);
    check("cap_tf", 64'(tf[3]), 64'd1);
    tf_clr = 8'h08; step("cap_clr"); tf_clr = '0;
    ch_in[3] = 0;
    for (int i = 0; i < 5; i++) step("cap_fall");
    check("cap_fall_ign", 64'(tf[3]), 64'd0);
    ch_in[3] = 1;
    step("cap_b1"); step("cap_b2");
    tf_clr = 8'h08; step("cap_race"); tf_clr = '0;
    check("cap_set_wins", 64'(tf[3]), 64'd1);

    // tc write with flag pending on channel 0
    check("fast_pre", 64'(tf[0]), 64'd1);
`ifdef TIMER_FAST_FLAG_CLR_EN
    tfca = 1;
`endif
    tc_wen = 8'h01; wdata = 8'h10; step("fast_wtc"); tc_wen = '0;
`ifdef TIMER_FAST_FLAG_CLR_EN
    check("fast_tf", 64'(tf[0]), 64'd0);
    tfca = 0;
`else
    check("fast_tf", 64'(tf[0]), 64'd1);
`endif

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      if (i % 50 == 0) begin
        ios = NCH'($urandom); om = NCH'($urandom); ol = NCH'($urandom);
        edge_a = NCH'($urandom); edge_b = NCH'($urandom); tie = NCH'($urandom);
        toi = 1'($urandom); tcre = 1'($urandom);
      end
      if (i % 97 == 0) pre = ($urandom % 5 == 0) ? PW'($urandom) : PW'($urandom % 3);
      ten      = ($urandom % 8) != 0;
      wdata    = CW'($urandom);
      tc_wen   = ($urandom % 10 == 0) ? NCH'(1 << ($urandom % NCH)) : '0;
      tcnt_wen = ($urandom % 40 == 0);
      tf_clr   = ($urandom % 4 == 0) ? NCH'($urandom) : '0;
      tovf_clr = ($urandom % 8 == 0);
      if ($urandom % 4 == 0) ch_in = ch_in ^ NCH'($urandom);
`ifdef TIMER_FAST_FLAG_CLR_EN
      tfca = 1'($urandom);
`endif
      step("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/timer_core_param.md
Name: timer_core_param

Overview:
- Parametrised successor to the fixed 8-channel, 32-bit APB timer core.
- Contains one free-running up-counter with a programmable prescaler, plus NUM_CH channels. Each channel is independently input capture (IC) or output compare (OC).
- Generates per-channel flags, an overflow flag and one combined interrupt.
- Sits behind the APB slave register file. The register file owns address decode and drives the config/strobe ports below.

Parameters:
- NUM_CH, 8, number of capture/compare channels (1..32)
- CNT_W, 32, counter and capture/compare register width (8..32)
- PRE_W, 3, width of prescaler select; divide ratio is 2^pre, maximum 2^(2^PRE_W - 1)

Ports:
- CLK  in  1  system clock
- nRST  in  1  asynchronous active-low reset
- ten  in  1  counter enable
- pre  in  PRE_W  prescaler select, tick every 2^pre CLK
- tcre  in  1  counter reset on compare match of channel NUM_CH-1
- ios  in  NUM_CH  per channel: 1=OC, 0=IC
- om, ol  in  NUM_CH each  OC action {om,ol}: 00 none, 01 toggle, 10 clear, 11 set
- edge_a, edge_b  in  NUM_CH each  IC edge {edge_b,edge_a}: 00 off, 01 rising, 10 falling, 11 both
- tie  in  NUM_CH  channel interrupt enables
- toi  in  1  overflow interrupt enable
- wdata  in  CNT_W  write data for tc/tcnt
- tc_wen  in  NUM_CH  one-hot write strobe per tc register
- tcnt_wen  in  1  counter load strobe
- tf_clr  in  NUM_CH  write-1-to-clear channel flags
- tovf_clr  in  1  clear overflow flag
- ch_in  in  NUM_CH  asynchronous capture pins
- ch_out  out  NUM_CH  compare output pins
- tcnt  out  CNT_W  counter value
- tc  out  NUM_CH*CNT_W  packed tc registers, channel n at [n*CNT_W +: CNT_W]
- tf  out  NUM_CH  channel flags
- tovf  out  1  overflow flag
- irq  out  1  |(tf & tie) | (tovf & toi), registered

Behaviour:
- Reset (nRST low, asynchronous): prescaler, tcnt, all tc, tf, tovf, ch_out, irq and synchroniser flops all 0.
- Prescaler:
  - Counter pcnt of width 2^PRE_W - 1 runs only while ten=1.
  - tick asserts for one CLK when pcnt[pre-1:0] is all-ones; pre=0 gives tick every cycle.
  - ten=0 freezes pcnt and tcnt.
  - A pre change takes effect immediately and pcnt is not cleared.
- Counter: on tick, tcnt <= tcnt+1, except:
  - (a) tcre=1, ios[NUM_CH-1]=1 and tcnt==tc[NUM_CH-1]: tcnt <= 0 and tovf is not set.
  - (b) tcnt all-ones (no tcre reset): wraps to 0 and tovf <= 1.
- tcnt_wen: tcnt <= wdata and pcnt <= 0 in the same edge. This has priority over tick.
- Compare (ios[n]=1): match when tick && tcnt==tc[n], using the pre-increment value. On the next edge:
  - tf[n] <= 1
  - ch_out[n] updated per {om,ol}
  - Latency: match cycle +1.
- Capture (ios[n]=0):
  - ch_in[n] passes a 2-flop synchroniser, then a third flop for edge detect.
  - A qualifying edge sets tc[n] <= tcnt and tf[n] <= 1 on the next edge.
  - Pin-to-flag latency is 3 CLK. Capture is not gated by tick, but is gated by ten=0 (disabled).
- Simultaneous events:
  - Flag set and tf_clr in the same cycle: set wins.
  - Capture and tc_wen on the same channel: capture wins.
  - tovf set and tovf_clr: set wins.
- An ios change does not clear tf or tc. ch_out holds its value when a channel becomes IC.
- irq: registered, one cycle after the flag/enable change.

Optional Feature:
- Macro TIMER_FAST_FLAG_CLR_EN.
- Defined:
  - Adds input tfca (1 bit).
  - When tfca=1, tc_wen[n] also clears tf[n], unless set in the same cycle (set wins).
  - tcnt_wen also clears tovf.
- Undefined: port absent; flags clear only via tf_clr/tovf_clr.

Decomposition:
- Package timer_param_pkg holds:
  - enum oc_action_t {OC_NONE, OC_TOGGLE, OC_CLEAR, OC_SET}
  - enum ic_edge_t {IC_OFF, IC_RISE, IC_FALL, IC_BOTH}
  - localparam defaults for NUM_CH, CNT_W, PRE_W
- Sub-module timer_channel, generate-instantiated NUM_CH times. It holds the synchroniser, edge detect, tc register, compare, flag and ch_out for one channel.
- The top holds the prescaler, tcnt, overflow and irq.

Test Plan:
- Reset/prescale: pre=2, ten=1 -> tcnt increments every 4 CLK; ten=0 for 10 cycles -> tcnt and pcnt frozen; nRST low mid-count -> all outputs 0 immediately.
- Overflow: CNT_W=8, tcnt_wen wdata=0xFE, pre=0 -> tcnt 0xFF, then 0x00 with tovf=1 one cycle later; toi=1 -> irq=1 next cycle; tovf_clr -> tovf=0.
- Compare/toggle: ch0 ios=1, tc0=0x10, {om,ol}=01, pre=0 -> tf[0]=1 and ch_out[0] toggles the cycle after tcnt==0x10; repeats every 2^CNT_W ticks.
- TCRE modulus: tcre=1, channel NUM_CH-1 OC, tc=9 -> tcnt sequence 0..9,0..; tovf never set.
- Capture: ch3 IC rising, drive ch_in[3] high when tcnt=0x40 (pre=0) -> tc3=0x42, tf[3]=1 three cycles after the pin edge; falling edge ignored; a tf_clr pulse coincident with a new capture leaves tf[3]=1.
- Optional: with TIMER_FAST_FLAG_CLR_EN and tfca=1, tc_wen[0] with tf[0]=1 -> tf[0]=0; without the macro -> tf[0] stays 1.
